// File: rtl/instr_stream_encoder_pkg.sv
// Shared RISC-V encoding types: instruction formats, field bundle, error codes,
// and the stream encoder's FSM state encoding.
package instr_stream_encoder_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } instr_type_enum;

  // imm holds a 32-bit two's-complement value; callers reinterpret it as signed.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_instr;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_TYPE  = 2'd3
  } enc_err_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_stream_if.sv
// Field-set input stream and encoded-word output stream of the encoder.
interface instr_stream_if;
  import instr_stream_encoder_pkg::*;

  logic           in_valid;
  logic           in_ready;
  instr_type_enum in_type;
  fields_instr    in_fields;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [31:0]    out_addr;
  logic           out_last;

  modport slave (
    input  in_valid, in_type, in_fields, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_last
  );

  modport master (
    output in_valid, in_type, in_fields, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_last
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational RV32 field packer with immediate range/alignment checks.
module instr_field_encoder
  import instr_stream_encoder_pkg::*;
(
  input  instr_type_enum type_i,
  input  fields_instr    fields_i,
  output logic [31:0]    instr_o,
  output enc_err_e       err_o
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(fields_i.imm);

  // True when v is representable as a bits-wide two's-complement value.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = v >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  always_comb begin
    instr_o = '0;
    err_o   = ERR_NONE;
    case (type_i)
      TYPE_R: instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                         fields_i.rd, fields_i.opcode};
      TYPE_I: begin
        instr_o = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
        if (!fits_signed(imm_s, 12)) err_o = ERR_RANGE;
      end
      TYPE_S: begin
        instr_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                   fields_i.imm[4:0], fields_i.opcode};
        if (!fits_signed(imm_s, 12)) err_o = ERR_RANGE;
      end
      TYPE_B: begin
        instr_o = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2, fields_i.rs1,
                   fields_i.funct3, fields_i.imm[4:1], fields_i.imm[11], fields_i.opcode};
        if (!fits_signed(imm_s, 13))  err_o = ERR_RANGE;
        else if (fields_i.imm[0])     err_o = ERR_ALIGN;
      end
      TYPE_U: begin
        instr_o = {fields_i.imm[31:12], fields_i.rd, fields_i.opcode};
        if (fields_i.imm[11:0] != 12'd0) err_o = ERR_ALIGN;
      end
      TYPE_J: begin
        instr_o = {fields_i.imm[20], fields_i.imm[10:1], fields_i.imm[11], fields_i.imm[19:12],
                   fields_i.rd, fields_i.opcode};
        if (!fits_signed(imm_s, 21))  err_o = ERR_RANGE;
        else if (fields_i.imm[0])     err_o = ERR_ALIGN;
      end
      default: err_o = ERR_TYPE;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program-load encoder: accepts field sets, encodes them, and streams words with
// byte addresses through a 2-entry output buffer to instruction memory.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  instr_stream_if.slave bus,
  output logic          err_valid,
  output enc_err_e      err_code,
  output logic          done,
  output logic [15:0]   word_count
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  enc_state_e  state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wc_q, wc_d;
  logic        err_valid_q, err_valid_d;
  enc_err_e    err_code_q, err_code_d;

  logic [31:0] instr_mem [2];
  logic [31:0] addr_mem  [2];
  logic        last_mem  [2];

  logic [31:0] enc_instr;
  enc_err_e    enc_err;
  logic        in_ready, accept, push, pop, start_run;

  instr_field_encoder u_enc (
    .type_i   (bus.in_type),
    .fields_i (bus.in_fields),
    .instr_o  (enc_instr),
    .err_o    (enc_err)
  );

  assign in_ready  = (state_q == S_RUN) && (count_q < DEPTH);
  assign accept    = bus.in_valid && in_ready;
  assign push      = accept && (enc_err == ERR_NONE);
  assign pop       = (count_q != 2'd0) && bus.out_ready;
  assign start_run = (state_q == S_IDLE) && start;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = instr_mem[rd_ptr_q];
  assign bus.out_addr  = addr_mem[rd_ptr_q];
  assign bus.out_last  = last_mem[rd_ptr_q];
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign done          = (state_q == S_DRAIN) && (count_q == 2'd0);
  assign word_count    = wc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && bus.in_last) state_d = S_DRAIN;
      S_DRAIN: if (count_q == 2'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;
    addr_d      = start_run ? BASE_ADDR : (push ? addr_q + 32'd4 : addr_q);
    wc_d        = wc_q;
    if (start_run)                 wc_d = '0;
    else if (pop && wc_q != '1)    wc_d = wc_q + 16'd1;
    err_valid_d = accept && (enc_err != ERR_NONE);
    err_code_d  = err_valid_d ? enc_err : ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      addr_q      <= BASE_ADDR;
      wc_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // Buffer payload carries no reset; occupancy is governed by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= enc_instr;
      addr_mem[wr_ptr_q]  <= addr_q;
      last_mem[wr_ptr_q]  <= bus.in_last;
    end
  end

endmodule
